ex_co_arbiter: RTL and testbench
================================

// Module: ex_co_arbiter
// PURPOSE
//  Producer side of the EX->CO interface: collects finished results from all FUs and emits at most
//  one EX_CO_PACKET per cycle into the registered ex_co_reg consumed by the complete stage.
//  One-entry holding slot per source; round-robin grant; per-source valid/ready backpressure; squash flush.
// PARAMETERS
//  NUM_SRC     8   number of FU result sources (ALU+MULT+LOAD+STORE+BRANCH FUs)
//  SRC_IDX_SZ  $clog2(NUM_SRC)  width of source index / round-robin pointer
// PORTS
//  clock        in   1            system clock; all state updates on posedge
//  reset        in   1            synchronous, active-low reset (0 = reset)
//  squash       in   1            mispredict flush; drops all held and in-flight results
//  src_valid    in   NUM_SRC      FU i presents a finished result this cycle
//  src_packet   in   EX_CO_PACKET [NUM_SRC]  result packet of FU i
//  src_ready    out  NUM_SRC      slot i can accept this cycle (combinational)
//  ex_co_reg    out  EX_CO_PACKET registered packet to complete stage; .valid marks occupancy
//  grant_idx    out  SRC_IDX_SZ   source index that produced current ex_co_reg (debug)
// BEHAVIOUR
//  Reset (reset==0 at posedge): slot_valid all 0, rr_ptr=0, ex_co_reg all-zero (.valid=0), grant_idx=0.
//  src_ready[i] = reset & ~squash & (~slot_valid[i] | grant[i]) -- slot freed by grant is refillable same cycle.
//  Accept: src_valid[i] & src_ready[i] -> slot[i] <= src_packet[i], slot_valid[i] <= 1 at next edge.
//  Grant (comb): first i with slot_valid[i], searching rr_ptr, rr_ptr+1, ... wrapping mod NUM_SRC; one-hot.
//  Output: ex_co_reg <= granted slot with .valid=1; no slot valid -> ex_co_reg.valid <= 0, other fields hold.
//  rr_ptr <= (granted idx + 1) mod NUM_SRC on a grant; unchanged otherwise. Wrap at NUM_SRC-1 -> 0.
//  Latency: accepted at edge N -> earliest ex_co_reg.valid after edge N+1 (2 edges); max wait NUM_SRC grants.
//  Granted & re-accepted same cycle: slot holds new packet, slot_valid stays 1.
//  Not granted: slot holds value, src_ready[i]=0 until granted; FU must hold its result.
//  squash=1 at edge: all slot_valid<=0, ex_co_reg.valid<=0, rr_ptr unchanged, no accepts that cycle.
//  Squash and reset together: reset wins (rr_ptr -> 0).
//  Packets passed unmodified except .valid; src_packet.valid ignored (src_valid is authoritative).
//  Throughput: exactly one packet/cycle whenever any slot is valid; never drops or duplicates.
// CONFIGURATION
//  EX_CO_ARB_BRANCH_PRIORITY_EN defined: any valid slot with function_type==BRANCH beats round-robin
//    (lowest index among BRANCH slots wins; rr_ptr advances past it as normal) -- resolves mispredicts early.
//  Undefined: pure round-robin, function_type ignored by the arbiter.
// STRUCTURE
//  sys_defs package: EX_CO_PACKET, FUNC_TYPE (ALU/MULT/LOAD/STORE/BRANCH), NUM_FU_* constants.
//  Sub-module rr_arbiter #(N): req[N], ptr -> one-hot gnt[N] + idx; purely combinational, reused by RS issue.
//  Top holds slots, rr_ptr, output register, priority override under the macro.
// TESTING
//  Reset: hold reset=0 3 cycles with src_valid=all 1 -> ex_co_reg.valid=0, src_ready=0, no slot captured.
//  Single: src_valid=8'b0000_0100, rob_index=5 at cycle 1 -> ex_co_reg.valid=1, rob_index=5, grant_idx=2 after 2 edges.
//  Fairness: all 8 sources valid every cycle from rr_ptr=0 -> grant_idx sequence 0,1,...,7,0; each src_ready 1 cycle in 8.
//  Wrap: rr_ptr=7, slots 7 and 0 valid -> grants 7 then 0; rr_ptr ends at 1.
//  Squash: slots 1,3,6 valid, squash=1 one cycle -> next ex_co_reg.valid=0, all src_ready=1 following cycle, no stale packet ever emitted.
//  Priority (macro on): rr_ptr=0, slot0 ALU, slot5 BRANCH -> grant 5 first then 0; macro off -> 0 then 5.

Source files
------------

// File: rtl/ex_co_arbiter_pkg.sv
// Shared types for the EX->CO result path: function-unit classes, the EX_CO packet and source sizing.
// Optional feature macro used by the arbiter: EX_CO_ARB_BRANCH_PRIORITY_EN.
package ex_co_arbiter_pkg;

  localparam int NUM_FU_ALU    = 3;
  localparam int NUM_FU_MULT   = 2;
  localparam int NUM_FU_LOAD   = 1;
  localparam int NUM_FU_STORE  = 1;
  localparam int NUM_FU_BRANCH = 1;

  localparam int NUM_SRC     = NUM_FU_ALU + NUM_FU_MULT + NUM_FU_LOAD + NUM_FU_STORE + NUM_FU_BRANCH;
  localparam int SRC_IDX_SZ  = $clog2(NUM_SRC);
  localparam int ROB_IDX_SZ  = 5;
  localparam int PREG_IDX_SZ = 6;

  typedef enum logic [2:0] {
    FUNC_ALU    = 3'd0,
    FUNC_MULT   = 3'd1,
    FUNC_LOAD   = 3'd2,
    FUNC_STORE  = 3'd3,
    FUNC_BRANCH = 3'd4
  } FUNC_TYPE;

  typedef struct packed {
    logic                   valid;
    logic [ROB_IDX_SZ-1:0]  rob_index;
    logic [PREG_IDX_SZ-1:0] dest_preg;
    logic [31:0]            result;
    FUNC_TYPE               function_type;
    logic                   take_branch;
  } EX_CO_PACKET;

  function automatic logic isBranch(input EX_CO_PACKET pkt);
    return pkt.function_type == FUNC_BRANCH;
  endfunction

endpackage

// File: rtl/ex_co_arbiter_if.sv
// Bundle between the functional units, the arbiter and the complete stage.
// The arbiter uses the master modport; FUs and the complete stage use slave.
interface ex_co_arbiter_if;
  import ex_co_arbiter_pkg::*;

  logic        [NUM_SRC-1:0]    src_valid;
  EX_CO_PACKET [NUM_SRC-1:0]    src_packet;
  logic        [NUM_SRC-1:0]    src_ready;
  EX_CO_PACKET                  ex_co_reg;
  logic        [SRC_IDX_SZ-1:0] grant_idx;

  modport master (
    input  src_valid,
    input  src_packet,
    output src_ready,
    output ex_co_reg,
    output grant_idx
  );

  modport slave (
    output src_valid,
    output src_packet,
    input  src_ready,
    input  ex_co_reg,
    input  grant_idx
  );

endinterface

// File: rtl/ex_co_arbiter_rr.sv
// Combinational round-robin arbiter: searches req starting at ptr and wrapping, one-hot grant.
// Shared with the reservation-station issue logic.
module rr_arbiter #(
  parameter  int N  = 8,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          any
);

  logic [IW-1:0] pos;

  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    pos = '0;
    for (int k = 0; k < N; k++) begin
      pos = IW'((int'(ptr) + k) % N);
      if (!any && req[pos]) begin
        any      = 1'b1;
        gnt[pos] = 1'b1;
        idx      = pos;
      end
    end
  end

endmodule

// File: rtl/ex_co_arbiter.sv
// EX->CO producer: one holding slot per FU, round-robin pick into the registered ex_co_reg.
// Define EX_CO_ARB_BRANCH_PRIORITY_EN to let BRANCH results bypass round-robin.
module ex_co_arbiter
  import ex_co_arbiter_pkg::*;
(
  input  logic            clock,
  input  logic            reset,
  input  logic            squash,
  ex_co_arbiter_if.master bus
);

  logic        [NUM_SRC-1:0]    slotValid_q, slotValid_d;
  EX_CO_PACKET [NUM_SRC-1:0]    slot_q, slot_d;
  EX_CO_PACKET                  exCoReg_q, exCoReg_d;
  logic        [SRC_IDX_SZ-1:0] grantIdx_q, grantIdx_d;
  logic        [SRC_IDX_SZ-1:0] rrPtr_q, rrPtr_d;

  logic        [NUM_SRC-1:0]    rrGnt, gnt, srcReady, accept;
  logic        [SRC_IDX_SZ-1:0] rrIdx, gntIdx;
  logic                         rrAny, anyGnt;

  rr_arbiter #(.N(NUM_SRC)) u_rr (
    .req (slotValid_q),
    .ptr (rrPtr_q),
    .gnt (rrGnt),
    .idx (rrIdx),
    .any (rrAny)
  );

`ifdef EX_CO_ARB_BRANCH_PRIORITY_EN
  logic branchFound;

  // Lowest-index valid BRANCH slot overrides the round-robin choice.
  always_comb begin
    gnt         = rrGnt;
    gntIdx      = rrIdx;
    anyGnt      = rrAny;
    branchFound = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (!branchFound && slotValid_q[i] && isBranch(slot_q[i])) begin
        branchFound = 1'b1;
        gnt         = '0;
        gnt[i]      = 1'b1;
        gntIdx      = SRC_IDX_SZ'(i);
        anyGnt      = 1'b1;
      end
    end
  end
`else
  assign gnt    = rrGnt;
  assign gntIdx = rrIdx;
  assign anyGnt = rrAny;
`endif

  // A slot being granted this cycle can take a new result at the same edge.
  assign srcReady = {NUM_SRC{reset & ~squash}} & (~slotValid_q | gnt);
  assign accept   = bus.src_valid & srcReady;

  always_comb begin
    slotValid_d = slotValid_q;
    slot_d      = slot_q;
    exCoReg_d   = exCoReg_q;
    grantIdx_d  = grantIdx_q;
    rrPtr_d     = rrPtr_q;
    if (squash) begin
      slotValid_d     = '0;
      exCoReg_d.valid = 1'b0;
    end else begin
      if (anyGnt) begin
        exCoReg_d       = slot_q[gntIdx];
        exCoReg_d.valid = 1'b1;
        grantIdx_d      = gntIdx;
        rrPtr_d         = (gntIdx == SRC_IDX_SZ'(NUM_SRC - 1)) ? '0 : gntIdx + SRC_IDX_SZ'(1);
        slotValid_d     = slotValid_q & ~gnt;
      end else begin
        exCoReg_d.valid = 1'b0;
      end
      for (int i = 0; i < NUM_SRC; i++) begin
        if (accept[i]) begin
          slot_d[i]      = bus.src_packet[i];
          slotValid_d[i] = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      slotValid_q <= '0;
      slot_q      <= '0;
      exCoReg_q   <= '0;
      grantIdx_q  <= '0;
      rrPtr_q     <= '0;
    end else begin
      slotValid_q <= slotValid_d;
      slot_q      <= slot_d;
      exCoReg_q   <= exCoReg_d;
      grantIdx_q  <= grantIdx_d;
      rrPtr_q     <= rrPtr_d;
    end
  end

  assign bus.src_ready = srcReady;
  assign bus.ex_co_reg = exCoReg_q;
  assign bus.grant_idx = grantIdx_q;

endmodule

// File: tb/tb_ex_co_arbiter.sv
// Bench for ex_co_arbiter: directed scenarios plus random traffic against a slot/queue-level model.
// Honours EX_CO_ARB_BRANCH_PRIORITY_EN in the model when the design is built with it.
module tb_ex_co_arbiter;
  import ex_co_arbiter_pkg::*;

`ifdef EX_CO_ARB_BRANCH_PRIORITY_EN
  localparam int PRIO_FIRST  = 5;
  localparam int PRIO_SECOND = 0;
`else
  localparam int PRIO_FIRST  = 0;
  localparam int PRIO_SECOND = 5;
`endif

  logic clock;
  logic reset;
  logic squash;

  ex_co_arbiter_if bus();

  ex_co_arbiter dut (
    .clock  (clock),
    .reset  (reset),
    .squash (squash),
    .bus    (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checkCount;
  int failCount;

  // Stimulus for the next cycle.
  logic        [NUM_SRC-1:0] stimValid;
  logic                      stimSquash;
  logic                      stimReset;
  EX_CO_PACKET               stimPkt [NUM_SRC];

  // Reference model: which FU results are waiting, whose turn it is, what was last emitted.
  bit          mSlotValid [NUM_SRC];
  EX_CO_PACKET mSlot      [NUM_SRC];
  int          mRr;
  EX_CO_PACKET mOut;
  int          mGrantIdx;

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    checkCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, actual, expected, $time);
    end
  endtask

  function automatic EX_CO_PACKET randPkt();
    EX_CO_PACKET p;
    p.valid         = 1'($urandom);
    p.rob_index     = ROB_IDX_SZ'($urandom);
    p.dest_preg     = PREG_IDX_SZ'($urandom);
    p.result        = $urandom;
    p.function_type = FUNC_TYPE'($urandom_range(0, 4));
    p.take_branch   = 1'($urandom);
    return p;
  endfunction

  // Whose result goes out this cycle, or -1 when nobody is waiting.
  function automatic int pickGrant();
`ifdef EX_CO_ARB_BRANCH_PRIORITY_EN
    for (int i = 0; i < NUM_SRC; i++)
      if (mSlotValid[i] && mSlot[i].function_type == FUNC_BRANCH) return i;
`endif
    for (int k = 0; k < NUM_SRC; k++) begin
      int i = (mRr + k) % NUM_SRC;
      if (mSlotValid[i]) return i;
    end
    return -1;
  endfunction

  task automatic stepCycle();
    int g;
    logic [NUM_SRC-1:0] expReady;
    @(negedge clock);
    reset         = stimReset;
    squash        = stimSquash;
    bus.src_valid = stimValid;
    for (int i = 0; i < NUM_SRC; i++) bus.src_packet[i] = stimPkt[i];
    #1;
    g = pickGrant();
    for (int i = 0; i < NUM_SRC; i++)
      expReady[i] = stimReset && !stimSquash && (!mSlotValid[i] || g == i);
    checkOutput("src_ready", 64'(bus.src_ready), 64'(expReady));

    if (!stimReset) begin
      for (int i = 0; i < NUM_SRC; i++) mSlotValid[i] = 1'b0;
      mRr       = 0;
      mOut      = '0;
      mGrantIdx = 0;
    end else if (stimSquash) begin
      for (int i = 0; i < NUM_SRC; i++) mSlotValid[i] = 1'b0;
      mOut.valid = 1'b0;
    end else begin
      if (g >= 0) begin
        mOut          = mSlot[g];
        mOut.valid    = 1'b1;
        mGrantIdx     = g;
        mRr           = (g + 1) % NUM_SRC;
        mSlotValid[g] = 1'b0;
      end else begin
        mOut.valid = 1'b0;
      end
      for (int i = 0; i < NUM_SRC; i++) begin
        if (stimValid[i] && expReady[i]) begin
          mSlot[i]      = stimPkt[i];
          mSlotValid[i] = 1'b1;
        end
      end
    end

    @(posedge clock);
    #1;
    checkOutput("ex_co_reg", 64'(bus.ex_co_reg), 64'(mOut));
    checkOutput("grant_idx", 64'(bus.grant_idx), 64'(mGrantIdx));
  endtask

  task automatic applyStimulus(input logic [NUM_SRC-1:0] v, input logic sq, input logic rst);
    stimValid  = v;
    stimSquash = sq;
    stimReset  = rst;
    stepCycle();
  endtask

  initial begin
    checkCount    = 0;
    failCount     = 0;
    reset         = 1'b0;
    squash        = 1'b0;
    bus.src_valid = '0;
    bus.src_packet = '0;
    mRr           = 0;
    mOut          = '0;
    mGrantIdx     = 0;
    for (int i = 0; i < NUM_SRC; i++) begin
      mSlotValid[i] = 1'b0;
      mSlot[i]      = '0;
      stimPkt[i]    = randPkt();
    end

    // Reset held with every source asserting.
    repeat (3) applyStimulus('1, 1'b0, 1'b0);
    checkOutput("rst_out_valid", 64'(bus.ex_co_reg.valid), 64'(0));
    checkOutput("rst_ready", 64'(bus.src_ready), 64'(0));

    // Single result from source 2.
    applyStimulus('0, 1'b0, 1'b1);
    stimPkt[2]           = randPkt();
    stimPkt[2].rob_index = ROB_IDX_SZ'(5);
    applyStimulus(8'b0000_0100, 1'b0, 1'b1);
    applyStimulus('0, 1'b0, 1'b1);
    checkOutput("single_valid", 64'(bus.ex_co_reg.valid), 64'(1));
    checkOutput("single_rob", 64'(bus.ex_co_reg.rob_index), 64'(5));
    checkOutput("single_idx", 64'(bus.grant_idx), 64'(2));

    // Fairness with all sources busy.
    applyStimulus('0, 1'b0, 1'b0);
    for (int k = 0; k < 10; k++) begin
      for (int i = 0; i < NUM_SRC; i++) stimPkt[i] = randPkt();
      applyStimulus('1, 1'b0, 1'b1);
      if (k >= 1) checkOutput("fair_idx", 64'(bus.grant_idx), 64'((k - 1) % NUM_SRC));
    end

    // Pointer wrap: park pointer at 7 via slot 6, then slots 7 and 0.
    applyStimulus('0, 1'b0, 1'b0);
    applyStimulus(8'h40, 1'b0, 1'b1);
    applyStimulus(8'h81, 1'b0, 1'b1);
    applyStimulus('0, 1'b0, 1'b1);
    checkOutput("wrap_first", 64'(bus.grant_idx), 64'(7));
    applyStimulus('0, 1'b0, 1'b1);
    checkOutput("wrap_second", 64'(bus.grant_idx), 64'(0));
    applyStimulus(8'h03, 1'b0, 1'b1);
    applyStimulus('0, 1'b0, 1'b1);
    checkOutput("wrap_ptr", 64'(bus.grant_idx), 64'(1));

    // Squash with slots 1, 3, 6 waiting.
    applyStimulus('0, 1'b0, 1'b0);
    applyStimulus(8'b0100_1010, 1'b0, 1'b1);
    applyStimulus('0, 1'b1, 1'b1);
    checkOutput("squash_valid", 64'(bus.ex_co_reg.valid), 64'(0));
    repeat (3) begin
      applyStimulus('0, 1'b0, 1'b1);
      checkOutput("squash_stale", 64'(bus.ex_co_reg.valid), 64'(0));
    end

    // ALU in slot 0, BRANCH in slot 5.
    applyStimulus('0, 1'b0, 1'b0);
    stimPkt[0]               = randPkt();
    stimPkt[0].function_type = FUNC_ALU;
    stimPkt[5]               = randPkt();
    stimPkt[5].function_type = FUNC_BRANCH;
    applyStimulus(8'h21, 1'b0, 1'b1);
    applyStimulus('0, 1'b0, 1'b1);
    checkOutput("prio_first", 64'(bus.grant_idx), 64'(PRIO_FIRST));
    applyStimulus('0, 1'b0, 1'b1);
    checkOutput("prio_second", 64'(bus.grant_idx), 64'(PRIO_SECOND));

    // Random traffic with occasional squash and reset.
    applyStimulus('0, 1'b0, 1'b0);
    repeat (400) begin
      for (int i = 0; i < NUM_SRC; i++) stimPkt[i] = randPkt();
      applyStimulus(NUM_SRC'($urandom), ($urandom_range(0, 19) == 0), ($urandom_range(0, 49) != 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule
